mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one single-port synchronous data memory between the instruction-fetch
// port (read-only) and the load-store port (read/write). Sits between the core
// and the memory array, ahead of LSU load formatting and I/O decode. Fixed
// LSU priority with a starvation counter that forces periodic fetch grants.
// Tracks the owner of each in-flight read and routes the returned word to it.
// PARAMETERS
// ADDR_W      14  word-address width (one address per 32-bit word)
// DATA_W      32  data width
// STARVE_MAX  3   consecutive denied fetch cycles before fetch wins; legal >= 1
// PORTS
// i_clk        in   1       clock, all state updates on rising edge
// i_reset      in   1       reset: synchronous, active-high
// i_if_req     in   1       fetch read request
// i_if_addr    in   ADDR_W  fetch word address
// o_if_gnt     out  1       fetch request accepted this cycle
// o_if_rvalid  out  1       fetch read data valid
// o_if_rdata   out  DATA_W  fetch read data
// i_ls_req     in   1       load-store request
// i_ls_wren    in   1       1 = write, 0 = read
// i_ls_bmask   in   4       write byte enables, bit k -> byte k
// i_ls_addr    in   ADDR_W  load-store word address
// i_ls_wdata   in   DATA_W  store data, byte-lane aligned
// o_ls_gnt     out  1       load-store request accepted this cycle
// o_ls_rvalid  out  1       load data valid
// o_ls_rdata   out  DATA_W  load data (raw word, unformatted)
// o_mem_addr   out  ADDR_W  memory word address
// o_mem_ren    out  1       memory read enable
// o_mem_wren   out  1       memory write enable
// o_mem_bmask  out  4       memory byte enables
// o_mem_wdata  out  DATA_W  memory write data
// i_mem_rdata  in   DATA_W  memory read data, valid 1 cycle after o_mem_ren
// BEHAVIOUR
// - Grant is combinational, same cycle as req. Requesters hold req/addr/data
//   stable until gnt. At most one gnt per cycle.
// - Arbitration: only one req -> it wins. Both -> LS wins unless
//   starve_cnt == STARVE_MAX, then IF wins. No req -> no gnt, mem idle.
// - starve_cnt (width $clog2(STARVE_MAX+1)): +1 when i_if_req && !o_if_gnt,
//   saturating at STARVE_MAX; cleared to 0 when o_if_gnt or !i_if_req.
//   Under continuous contention IF wins 1 of every STARVE_MAX+1 cycles.
// - Memory command from winner, same cycle: addr muxed; IF -> ren=1, wren=0,
//   bmask=0; LS read -> ren=1, bmask=0; LS write -> wren=1, bmask=i_ls_bmask,
//   wdata=i_ls_wdata. No winner: ren=wren=0, bmask=0, addr/wdata=0.
// - LS write with bmask=0 is still granted and issued; no bytes change.
// - Read owner FSM (rd_owner): NONE/IF/LS. Next state = IF if IF read granted,
//   LS if LS read granted, else NONE (LS writes -> NONE). Read latency 1 cycle:
//   o_if_rvalid = (rd_owner==IF), o_ls_rvalid = (rd_owner==LS); the valid
//   port's rdata = i_mem_rdata, the other port's rdata = 0. Never both valid.
// - Back-to-back reads from either port sustain 1 access/cycle.
// - Reset (i_reset=1 at edge): starve_cnt=0, rd_owner=NONE. While i_reset is
//   high: both gnt=0, ren=wren=0, bmask=0, rvalids=0, rdatas=0. A read
//   granted the cycle before reset produces no rvalid.
// TESTING
// 1 Reset 2 cycles with both reqs high -> gnts, ren, wren, rvalids all 0;
//   first cycle after release LS granted, starve_cnt 0->1.
// 2 IF-only read addr 0x010, mem returns 0xDEADBEEF -> o_if_gnt=1, mem_addr
//   0x010, ren=1 same cycle; next cycle o_if_rvalid=1, rdata 0xDEADBEEF.
// 3 STARVE_MAX=2, both reqs held high 6 cycles -> grants LS,LS,IF,LS,LS,IF.
// 4 LS write addr 0x005, bmask 4'b0011, wdata 0x12345678 -> wren=1, bmask
//   0011, wdata passed; next cycle both rvalid=0.
// 5 LS read 0x001 cycle N, IF read 0x002 cycle N+1 -> ls_rvalid at N+1 with
//   word@0x001, if_rvalid at N+2 with word@0x002, never overlapping.
// 6 IF read granted cycle N, i_reset=1 at N+1 -> no rvalid at N+1 or N+2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous data memory between instruction fetch
// (read-only) and load-store, and steers each returned read word to its owner.
module mem_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic              i_ls_wren,
    input  logic [3:0]        i_ls_bmask,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wren,
    output logic [3:0]        o_mem_bmask,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    logic [CNT_W-1:0] starve_q, starve_d;
    owner_e           owner_q, owner_d;
    logic             ifWin, lsWin;

    // LS has priority unless fetch has been denied STARVE_MAX cycles in a row.
    always_comb begin
        ifWin = !i_reset && i_if_req && (!i_ls_req || (starve_q == STARVE_LIM));
        lsWin = !i_reset && i_ls_req && !ifWin;
    end

    always_comb begin
        starve_d = starve_q;
        if (!i_if_req || ifWin) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end

        owner_d = OWN_NONE;
        if (ifWin) begin
            owner_d = OWN_IF;
        end else if (lsWin && !i_ls_wren) begin
            owner_d = OWN_LS;
        end
    end

    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_bmask = 4'b0000;
        o_mem_wdata = '0;
        if (ifWin) begin
            o_mem_addr = i_if_addr;
            o_mem_ren  = 1'b1;
        end else if (lsWin) begin
            o_mem_addr = i_ls_addr;
            if (i_ls_wren) begin
                o_mem_wren  = 1'b1;
                o_mem_bmask = i_ls_bmask;
                o_mem_wdata = i_ls_wdata;
            end else begin
                o_mem_ren = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_q <= '0;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Returned data is gated by reset so a read issued just before reset is dropped.
    always_comb begin
        o_if_gnt    = ifWin;
        o_ls_gnt    = lsWin;
        o_if_rvalid = !i_reset && (owner_q == OWN_IF);
        o_ls_rvalid = !i_reset && (owner_q == OWN_LS);
        o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
        o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of per-cycle vectors plus a few
// hand-written sequences, against a small bench-side memory model.
module tb_mem_port_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifReq = 1'b0, lsReq = 1'b0, lsWren = 1'b0;
    logic [AW-1:0] ifAddr = '0, lsAddr = '0;
    logic [3:0]    lsBmask = '0;
    logic [DW-1:0] lsWdata = '0;
    logic          ifGnt, ifRvalid, lsGnt, lsRvalid, memRen, memWren;
    logic [DW-1:0] ifRdata, lsRdata, memWdata;
    logic [DW-1:0] memRdata = '0;
    logic [AW-1:0] memAddr;
    logic [3:0]    memBmask;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic          rst, ifReq, lsReq, lsWren;
        logic [AW-1:0] ifAddr, lsAddr;
        logic [3:0]    lsBmask;
        logic [DW-1:0] lsWdata;
        logic          eIfGnt, eLsGnt, eRen, eWren;
        logic [AW-1:0] eAddr;
        logic [3:0]    eBmask;
        logic [DW-1:0] eWdata;
        logic          eIfRv, eLsRv;
        logic [DW-1:0] eIfRd, eLsRd;
    } vec_t;

    vec_t vecs[$];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(2)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(ifReq), .i_if_addr(ifAddr), .o_if_gnt(ifGnt),
        .o_if_rvalid(ifRvalid), .o_if_rdata(ifRdata),
        .i_ls_req(lsReq), .i_ls_wren(lsWren), .i_ls_bmask(lsBmask),
        .i_ls_addr(lsAddr), .i_ls_wdata(lsWdata), .o_ls_gnt(lsGnt),
        .o_ls_rvalid(lsRvalid), .o_ls_rdata(lsRdata),
        .o_mem_addr(memAddr), .o_mem_ren(memRen), .o_mem_wren(memWren),
        .o_mem_bmask(memBmask), .o_mem_wdata(memWdata), .i_mem_rdata(memRdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return (a == 14'h010) ? 32'hDEADBEEF : {16'hA5A5, 2'b00, a};
    endfunction

    // Synchronous memory model: data one cycle after ren, junk otherwise.
    always @(posedge clk) begin
        memRdata <= memRen ? memWord(memAddr) : 32'h0BADF00D;
    end

    function automatic vec_t mk(
        input logic rs, iq, input logic [AW-1:0] ia,
        input logic lq, lw, input logic [3:0] lb, input logic [AW-1:0] la, input logic [DW-1:0] ld,
        input logic eig, elg, input logic [AW-1:0] ea, input logic er, ew,
        input logic [3:0] eb, input logic [DW-1:0] ewd,
        input logic eir, input logic [DW-1:0] eid, input logic elr, input logic [DW-1:0] eld);
        vec_t v;
        v.rst = rs; v.ifReq = iq; v.ifAddr = ia;
        v.lsReq = lq; v.lsWren = lw; v.lsBmask = lb; v.lsAddr = la; v.lsWdata = ld;
        v.eIfGnt = eig; v.eLsGnt = elg; v.eAddr = ea; v.eRen = er; v.eWren = ew;
        v.eBmask = eb; v.eWdata = ewd;
        v.eIfRv = eir; v.eIfRd = eid; v.eLsRv = elr; v.eLsRd = eld;
        return v;
    endfunction

    task automatic check1(input string tag, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s %s actual=%0h expected=%0h", tag, name, act, exp);
        end
    endtask

    // Drives one cycle's inputs just after the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rst = v.rst; ifReq = v.ifReq; ifAddr = v.ifAddr;
        lsReq = v.lsReq; lsWren = v.lsWren; lsBmask = v.lsBmask;
        lsAddr = v.lsAddr; lsWdata = v.lsWdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        check1(tag, "ifGnt", 32'(ifGnt), 32'(v.eIfGnt));
        check1(tag, "lsGnt", 32'(lsGnt), 32'(v.eLsGnt));
        check1(tag, "memAddr", 32'(memAddr), 32'(v.eAddr));
        check1(tag, "memRen", 32'(memRen), 32'(v.eRen));
        check1(tag, "memWren", 32'(memWren), 32'(v.eWren));
        check1(tag, "memBmask", 32'(memBmask), 32'(v.eBmask));
        check1(tag, "memWdata", memWdata, v.eWdata);
        check1(tag, "ifRvalid", 32'(ifRvalid), 32'(v.eIfRv));
        check1(tag, "ifRdata", ifRdata, v.eIfRd);
        check1(tag, "lsRvalid", 32'(lsRvalid), 32'(v.eLsRv));
        check1(tag, "lsRdata", lsRdata, v.eLsRd);
    endtask

    task automatic runVec(input string tag, input vec_t v);
        applyStimulus(v);
        checkOutput(tag, v);
    endtask

    initial begin
        // Reset with both requesters active, then LS wins first.
        vecs.push_back(mk(1,1,14'h010, 1,0,4'h0,14'h020,0, 0,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(1,1,14'h010, 1,0,4'h0,14'h020,0, 0,0,0,0,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,14'h010, 1,0,4'h0,14'h020,0, 0,1,14'h020,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,1,32'hA5A50020));
        // IF-only read.
        vecs.push_back(mk(0,1,14'h010, 0,0,0,0,0, 1,0,14'h010,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,32'hDEADBEEF,0,0));
        // Continuous contention, STARVE_MAX=2: LS,LS,IF,LS,LS,IF.
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 0,1,14'h004,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 0,1,14'h004,1,0,0,0, 0,0,1,32'hA5A50004));
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 1,0,14'h003,1,0,0,0, 0,0,1,32'hA5A50004));
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 0,1,14'h004,1,0,0,0, 1,32'hA5A50003,0,0));
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 0,1,14'h004,1,0,0,0, 0,0,1,32'hA5A50004));
        vecs.push_back(mk(0,1,14'h003, 1,0,0,14'h004,0, 1,0,14'h003,1,0,0,0, 0,0,1,32'hA5A50004));
        // LS write with partial byte mask, then no read data follows.
        vecs.push_back(mk(0,0,0, 1,1,4'b0011,14'h005,32'h12345678,
                          0,1,14'h005,0,1,4'b0011,32'h12345678, 1,32'hA5A50003,0,0));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
        // LS read then IF read back to back.
        vecs.push_back(mk(0,0,0, 1,0,0,14'h001,0, 0,1,14'h001,1,0,0,0, 0,0,0,0));
        vecs.push_back(mk(0,1,14'h002, 0,0,0,0,0, 1,0,14'h002,1,0,0,0, 0,0,1,32'hA5A50001));
        vecs.push_back(mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 1,32'hA5A50002,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Read granted the cycle before reset must never return data.
        runVec("rstRd0", mk(0,1,14'h010, 0,0,0,0,0, 1,0,14'h010,1,0,0,0, 0,0,0,0));
        runVec("rstRd1", mk(1,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));
        runVec("rstRd2", mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));

        // Dropping the fetch request clears the starvation count.
        runVec("clr0", mk(0,1,14'h007, 1,0,0,14'h008,0, 0,1,14'h008,1,0,0,0, 0,0,0,0));
        runVec("clr1", mk(0,1,14'h007, 1,0,0,14'h008,0, 0,1,14'h008,1,0,0,0, 0,0,1,32'hA5A50008));
        runVec("clr2", mk(0,0,0, 1,0,0,14'h008,0, 0,1,14'h008,1,0,0,0, 0,0,1,32'hA5A50008));
        runVec("clr3", mk(0,1,14'h007, 1,0,0,14'h008,0, 0,1,14'h008,1,0,0,0, 0,0,1,32'hA5A50008));

        // Zero-byte-mask write is still granted and issued.
        runVec("bm0", mk(0,0,0, 1,1,4'b0000,14'h009,32'hCAFEF00D,
                         0,1,14'h009,0,1,4'b0000,32'hCAFEF00D, 0,0,1,32'hA5A50008));
        runVec("bm1", mk(0,0,0, 0,0,0,0,0, 0,0,0,0,0,0,0, 0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
